// File: rtl/coalescing_store_buffer.sv
// Two-level store buffer: a speculative FIFO feeding a commit FIFO that drains to the D$ write port.
// Commits to the same aligned word as the youngest non-head commit entry are merged into that entry.
module coalescing_store_buffer #(
  parameter int XLEN         = 64,
  parameter int PLEN         = 56,
  parameter int SPEC_DEPTH   = 4,
  parameter int COMMIT_DEPTH = 8,
  parameter bit COALESCE_EN  = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [PLEN-1:0]   paddr_i,
  input  logic [XLEN-1:0]   data_i,
  input  logic [XLEN/8-1:0] be_i,
  input  logic [1:0]        data_size_i,
  input  logic              commit_i,
  output logic              commit_ready_o,
  input  logic [11:0]       page_offset_i,
  output logic              page_offset_matches_o,
  output logic              no_st_pending_o,
  output logic              empty_o,
  output logic              req_o,
  output logic [PLEN-1:0]   req_addr_o,
  output logic [XLEN-1:0]   req_data_o,
  output logic [XLEN/8-1:0] req_be_o,
  output logic [1:0]        req_size_o,
  input  logic              gnt_i
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int SPW   = $clog2(SPEC_DEPTH);
  localparam int CPW   = $clog2(COMMIT_DEPTH);
  localparam logic [SPW:0] SPEC_FULL   = (SPW+1)'(SPEC_DEPTH);
  localparam logic [CPW:0] COMMIT_FULL = (CPW+1)'(COMMIT_DEPTH);
  localparam logic [CPW:0] CNT_TWO     = (CPW+1)'(2);
  localparam logic [1:0]   WORD_SIZE   = 2'(OFF);

  typedef struct packed {
    logic [PLEN-1:0]  addr;
    logic [XLEN-1:0]  data;
    logic [BYTES-1:0] be;
    logic [1:0]       size;
  } entry_t;

  entry_t         sq_q [SPEC_DEPTH];
  entry_t         sq_d [SPEC_DEPTH];
  entry_t         cq_q [COMMIT_DEPTH];
  entry_t         cq_d [COMMIT_DEPTH];
  logic [SPW-1:0] spec_rd_q, spec_rd_d, spec_wr_q, spec_wr_d;
  logic [SPW:0]   spec_cnt_q, spec_cnt_d;
  logic [CPW-1:0] commit_rd_q, commit_rd_d, commit_wr_q, commit_wr_d;
  logic [CPW:0]   commit_cnt_q, commit_cnt_d;

  logic           spec_push_s, spec_pop_s, gnt_pop_s, coalesce_s;
  logic [CPW-1:0] cq_last_s;
  entry_t         new_entry_s, commit_entry_s, merged_s, head_s;
  logic           unused_page_bits_s;

  assign ready_o            = spec_cnt_q < SPEC_FULL;
  assign commit_ready_o     = commit_cnt_q < COMMIT_FULL;
  assign req_o              = commit_cnt_q != {(CPW+1){1'b0}};
  assign no_st_pending_o    = commit_cnt_q == {(CPW+1){1'b0}};
  assign empty_o            = (spec_cnt_q == {(SPW+1){1'b0}}) && no_st_pending_o;
  assign unused_page_bits_s = ^page_offset_i[OFF-1:0];

  assign spec_push_s    = valid_i && ready_o && !flush_i;
  assign spec_pop_s     = commit_i && (spec_cnt_q != {(SPW+1){1'b0}}) && commit_ready_o && !flush_i;
  assign gnt_pop_s      = gnt_i && req_o;
  assign cq_last_s      = commit_wr_q - {{(CPW-1){1'b0}}, 1'b1};
  assign commit_entry_s = sq_q[spec_rd_q];
  assign head_s         = cq_q[commit_rd_q];
  assign new_entry_s    = '{addr: paddr_i, data: data_i, be: be_i, size: data_size_i};

  // Merge candidate: youngest commit entry overlaid with the committing store's enabled bytes.
  always_comb begin
    coalesce_s = COALESCE_EN && (commit_cnt_q >= CNT_TWO) && (cq_last_s != commit_rd_q) &&
                 (cq_q[cq_last_s].addr[PLEN-1:OFF] == commit_entry_s.addr[PLEN-1:OFF]);
    merged_s = cq_q[cq_last_s];
    for (int b = 0; b < BYTES; b++) begin
      if (commit_entry_s.be[b]) begin
        merged_s.data[8*b +: 8] = commit_entry_s.data[8*b +: 8];
      end else begin
        merged_s.data[8*b +: 8] = cq_q[cq_last_s].data[8*b +: 8];
      end
    end
    merged_s.be   = cq_q[cq_last_s].be | commit_entry_s.be;
    merged_s.size = WORD_SIZE;
  end

  // Next-state for both queues' storage, pointers and occupancy.
  always_comb begin
    sq_d = sq_q;
    cq_d = cq_q;
    if (spec_push_s) begin
      sq_d[spec_wr_q] = new_entry_s;
    end else begin
      sq_d[spec_wr_q] = sq_q[spec_wr_q];
    end
    if (spec_pop_s && coalesce_s) begin
      cq_d[cq_last_s] = merged_s;
    end else if (spec_pop_s) begin
      cq_d[commit_wr_q] = commit_entry_s;
    end else begin
      cq_d[commit_wr_q] = cq_q[commit_wr_q];
    end

    if (flush_i) begin
      spec_rd_d  = {SPW{1'b0}};
      spec_wr_d  = {SPW{1'b0}};
      spec_cnt_d = {(SPW+1){1'b0}};
    end else begin
      spec_rd_d  = spec_rd_q + SPW'(spec_pop_s);
      spec_wr_d  = spec_wr_q + SPW'(spec_push_s);
      spec_cnt_d = spec_cnt_q + (SPW+1)'(spec_push_s) - (SPW+1)'(spec_pop_s);
    end

    commit_rd_d  = commit_rd_q + CPW'(gnt_pop_s);
    commit_wr_d  = commit_wr_q + CPW'(spec_pop_s && !coalesce_s);
    commit_cnt_d = commit_cnt_q + (CPW+1)'(spec_pop_s && !coalesce_s) - (CPW+1)'(gnt_pop_s);
  end

  // Pointer and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spec_rd_q    <= {SPW{1'b0}};
      spec_wr_q    <= {SPW{1'b0}};
      spec_cnt_q   <= {(SPW+1){1'b0}};
      commit_rd_q  <= {CPW{1'b0}};
      commit_wr_q  <= {CPW{1'b0}};
      commit_cnt_q <= {(CPW+1){1'b0}};
    end else begin
      spec_rd_q    <= spec_rd_d;
      spec_wr_q    <= spec_wr_d;
      spec_cnt_q   <= spec_cnt_d;
      commit_rd_q  <= commit_rd_d;
      commit_wr_q  <= commit_wr_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  // Entry storage; validity comes solely from the pointers, so no reset is needed.
  always_ff @(posedge clk_i) begin
    sq_q <= sq_d;
    cq_q <= cq_d;
  end

  // Load hazard check across every live entry of both queues.
  always_comb begin
    page_offset_matches_o = 1'b0;
    for (int i = 0; i < SPEC_DEPTH; i++) begin
      if (({1'b0, SPW'(i) - spec_rd_q} < spec_cnt_q) &&
          (sq_q[i].addr[11:OFF] == page_offset_i[11:OFF])) begin
        page_offset_matches_o = 1'b1;
      end else begin
        page_offset_matches_o = page_offset_matches_o;
      end
    end
    for (int i = 0; i < COMMIT_DEPTH; i++) begin
      if (({1'b0, CPW'(i) - commit_rd_q} < commit_cnt_q) &&
          (cq_q[i].addr[11:OFF] == page_offset_i[11:OFF])) begin
        page_offset_matches_o = 1'b1;
      end else begin
        page_offset_matches_o = page_offset_matches_o;
      end
    end
  end

  // Head entry is presented only while a request is outstanding, otherwise zeros.
  always_comb begin
    if (req_o) begin
      req_addr_o = head_s.addr;
      req_data_o = head_s.data;
      req_be_o   = head_s.be;
      req_size_o = head_s.size;
    end else begin
      req_addr_o = {PLEN{1'b0}};
      req_data_o = {XLEN{1'b0}};
      req_be_o   = {BYTES{1'b0}};
      req_size_o = 2'b00;
    end
  end

endmodule

// File: tb/tb_coalescing_store_buffer.sv
// Directed bench for coalescing_store_buffer (XLEN=64, PLEN=56, SPEC_DEPTH=4, COMMIT_DEPTH=8).
module tb_coalescing_store_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, valid_i, commit_i, gnt_i;
  logic [55:0] paddr_i;
  logic [63:0] data_i;
  logic [7:0]  be_i;
  logic [1:0]  data_size_i;
  logic [11:0] page_offset_i;
  logic        ready_o, commit_ready_o, page_offset_matches_o, no_st_pending_o, empty_o, req_o;
  logic [55:0] req_addr_o;
  logic [63:0] req_data_o;
  logic [7:0]  req_be_o;
  logic [1:0]  req_size_o;

  int n_vec  = 0;
  int n_miss = 0;

  coalescing_store_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .paddr_i(paddr_i), .data_i(data_i), .be_i(be_i), .data_size_i(data_size_i),
    .commit_i(commit_i), .commit_ready_o(commit_ready_o), .page_offset_i(page_offset_i),
    .page_offset_matches_o(page_offset_matches_o), .no_st_pending_o(no_st_pending_o),
    .empty_o(empty_o), .req_o(req_o), .req_addr_o(req_addr_o), .req_data_o(req_data_o),
    .req_be_o(req_be_o), .req_size_o(req_size_o), .gnt_i(gnt_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        valid;
    logic [55:0] paddr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [1:0]  size;
    logic        commit;
    logic        gnt;
    logic [11:0] poff;
    logic [134:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(input logic valid, input logic [55:0] paddr, input logic [63:0] data,
                             input logic [7:0] be, input logic [1:0] size, input logic commit,
                             input logic gnt, input logic [11:0] poff, input logic e_ready,
                             input logic e_cready, input logic e_req, input logic [55:0] e_addr,
                             input logic [63:0] e_data, input logic [7:0] e_be,
                             input logic [1:0] e_size, input logic e_empty, input logic e_match);
    vec_t r;
    r.valid = valid; r.paddr = paddr; r.data = data; r.be = be; r.size = size;
    r.commit = commit; r.gnt = gnt; r.poff = poff;
    r.exp = {e_ready, e_cready, e_req, e_addr, e_data, e_be, e_size, e_empty, e_match};
    return r;
  endfunction

  task automatic drv(input logic valid, input logic [55:0] paddr, input logic [63:0] data,
                     input logic [7:0] be, input logic [1:0] size, input logic commit,
                     input logic gnt, input logic flush, input logic [11:0] poff);
    valid_i = valid; paddr_i = paddr; data_i = data; be_i = be; data_size_i = size;
    commit_i = commit; gnt_i = gnt; flush_i = flush; page_offset_i = poff;
  endtask

  task automatic idle;
    drv(1'b0, 56'h0, 64'h0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample;
    @(negedge clk_i);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Upstream must never push into a full speculative queue.
  always @(negedge clk_i) begin
    if (!rst_i && valid_i === 1'b1 && ready_o === 1'b0) begin
      n_miss++;
      $display("FAIL protocol: valid_i asserted while ready_o=0");
    end
  end

  initial begin
    logic [134:0] act;
    // in: valid paddr data be size commit gnt poff | exp: ready cready req addr data be size empty match
    vq.push_back(v(0, 56'h0,    64'h0,    8'h00, 2'd0, 0, 0, 12'h000, 1, 1, 0, 56'h0,    64'h0,    8'h00, 2'd0, 1, 0));
    vq.push_back(v(0, 56'h0,    64'h0,    8'h00, 2'd0, 0, 0, 12'h000, 1, 1, 0, 56'h0,    64'h0,    8'h00, 2'd0, 1, 0));
    vq.push_back(v(0, 56'h0,    64'h0,    8'h00, 2'd0, 0, 0, 12'h000, 1, 1, 0, 56'h0,    64'h0,    8'h00, 2'd0, 1, 0));
    vq.push_back(v(1, 56'h1000, 64'hAABB, 8'h03, 2'd1, 0, 1, 12'h000, 1, 1, 0, 56'h0,    64'h0,    8'h00, 2'd0, 1, 0));
    vq.push_back(v(0, 56'h0,    64'h0,    8'h00, 2'd0, 1, 1, 12'h000, 1, 1, 0, 56'h0,    64'h0,    8'h00, 2'd0, 0, 1));
    vq.push_back(v(0, 56'h0,    64'h0,    8'h00, 2'd0, 0, 1, 12'h008, 1, 1, 1, 56'h1000, 64'hAABB, 8'h03, 2'd1, 0, 0));
    vq.push_back(v(0, 56'h0,    64'h0,    8'h00, 2'd0, 1, 1, 12'h000, 1, 1, 0, 56'h0,    64'h0,    8'h00, 2'd0, 1, 0));
    vq.push_back(v(1, 56'h2000, 64'h11223344, 8'h0F, 2'd2, 0, 0, 12'h000, 1, 1, 0, 56'h0, 64'h0, 8'h00, 2'd0, 1, 0));
    vq.push_back(v(1, 56'h3000, 64'h77,   8'h01, 2'd0, 1, 0, 12'h008, 1, 1, 0, 56'h0,    64'h0,    8'h00, 2'd0, 0, 0));
    vq.push_back(v(1, 56'h3004, 64'h0000005500000000, 8'h10, 2'd0, 1, 0, 12'h008, 1, 1, 1, 56'h2000, 64'h11223344, 8'h0F, 2'd2, 0, 0));
    vq.push_back(v(0, 56'h0,    64'h0,    8'h00, 2'd0, 1, 0, 12'h008, 1, 1, 1, 56'h2000, 64'h11223344, 8'h0F, 2'd2, 0, 0));
    vq.push_back(v(0, 56'h0,    64'h0,    8'h00, 2'd0, 0, 1, 12'h008, 1, 1, 1, 56'h2000, 64'h11223344, 8'h0F, 2'd2, 0, 0));
    vq.push_back(v(0, 56'h0,    64'h0,    8'h00, 2'd0, 0, 1, 12'h008, 1, 1, 1, 56'h3000, 64'h0000005500000077, 8'h11, 2'd3, 0, 0));
    vq.push_back(v(0, 56'h0,    64'h0,    8'h00, 2'd0, 0, 0, 12'h008, 1, 1, 0, 56'h0,    64'h0,    8'h00, 2'd0, 1, 0));
    vq.push_back(v(1, 56'h5A48, 64'h1,    8'hFF, 2'd3, 0, 0, 12'hA4C, 1, 1, 0, 56'h0,    64'h0,    8'h00, 2'd0, 1, 0));
    vq.push_back(v(0, 56'h0,    64'h0,    8'h00, 2'd0, 1, 0, 12'hA4C, 1, 1, 0, 56'h0,    64'h0,    8'h00, 2'd0, 0, 1));
    vq.push_back(v(0, 56'h0,    64'h0,    8'h00, 2'd0, 0, 0, 12'hA50, 1, 1, 1, 56'h5A48, 64'h1,    8'hFF, 2'd3, 0, 0));
    vq.push_back(v(0, 56'h0,    64'h0,    8'h00, 2'd0, 0, 1, 12'hA4C, 1, 1, 1, 56'h5A48, 64'h1,    8'hFF, 2'd3, 0, 1));
    vq.push_back(v(0, 56'h0,    64'h0,    8'h00, 2'd0, 0, 0, 12'hA4C, 1, 1, 0, 56'h0,    64'h0,    8'h00, 2'd0, 1, 0));

    idle();
    rst_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;

    for (int c = 0; c < 10; c++) begin
      sample();
      chk("reset_idle", {58'h0, ready_o, commit_ready_o, empty_o, no_st_pending_o, req_o, page_offset_matches_o},
          {58'h0, 6'b111_100});
      chk("reset_req_addr", {8'h0, req_addr_o}, 64'h0);
      tick();
    end

    foreach (vq[i]) begin
      drv(vq[i].valid, vq[i].paddr, vq[i].data, vq[i].be, vq[i].size, vq[i].commit, vq[i].gnt,
          1'b0, vq[i].poff);
      sample();
      act = {ready_o, commit_ready_o, req_o, req_addr_o, req_data_o, req_be_o, req_size_o,
             empty_o, page_offset_matches_o};
      n_vec++;
      if (act !== vq[i].exp) begin
        n_miss++;
        $display("FAIL vec%0d: got %h expected %h", i, act, vq[i].exp);
      end
      tick();
    end

    // Flush: two committed, three speculative, then a flush carrying a stray push and commit.
    drv(1'b1, 56'h100, 64'h1, 8'hFF, 2'd3, 1'b0, 1'b0, 1'b0, 12'h000); tick();
    drv(1'b1, 56'h108, 64'h2, 8'hFF, 2'd3, 1'b1, 1'b0, 1'b0, 12'h000); tick();
    drv(1'b1, 56'h110, 64'h3, 8'hFF, 2'd3, 1'b1, 1'b0, 1'b0, 12'h000); tick();
    drv(1'b1, 56'h118, 64'h4, 8'hFF, 2'd3, 1'b0, 1'b0, 1'b0, 12'h000); tick();
    drv(1'b1, 56'h120, 64'h5, 8'hFF, 2'd3, 1'b0, 1'b0, 1'b0, 12'h000); tick();
    drv(1'b1, 56'h128, 64'h6, 8'hFF, 2'd3, 1'b1, 1'b0, 1'b1, 12'h000); sample();
    chk("flush_cycle_req", {63'h0, req_o}, 64'h1);
    tick();
    drv(1'b0, 56'h0, 64'h0, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0, 12'h110); sample();
    chk("post_flush_ready", {63'h0, ready_o}, 64'h1);
    chk("post_flush_req_addr", {8'h0, req_addr_o}, 64'h100);
    chk("post_flush_match_gone", {63'h0, page_offset_matches_o}, 64'h0);
    tick();
    drv(1'b0, 56'h0, 64'h0, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0, 12'h108); sample();
    chk("flush_second_grant", {8'h0, req_addr_o}, 64'h108);
    chk("flush_commit_match", {63'h0, page_offset_matches_o}, 64'h1);
    tick();
    idle(); sample();
    chk("flush_drained_empty", {62'h0, empty_o, req_o}, 64'h2);
    tick();

    // Backpressure: fill the speculative queue, then fill the commit queue with distinct words.
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 56'h4000 + 56'(8 * k), 64'(k), 8'hFF, 2'd3, 1'b0, 1'b0, 1'b0, 12'h000); sample();
      chk("spec_fill_ready", {63'h0, ready_o}, 64'h1);
      tick();
    end
    idle(); sample();
    chk("spec_full_ready", {63'h0, ready_o}, 64'h0);
    tick();
    drv(1'b0, 56'h0, 64'h0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 12'h000); tick();
    for (int k = 4; k < 11; k++) begin
      drv(1'b1, 56'h4000 + 56'(8 * k), 64'(k), 8'hFF, 2'd3, 1'b1, 1'b0, 1'b0, 12'h000); sample();
      chk("commit_fill_cready", {63'h0, commit_ready_o}, 64'h1);
      tick();
    end
    drv(1'b0, 56'h0, 64'h0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 12'h000); sample();
    chk("commit_full_cready", {62'h0, commit_ready_o, ready_o}, 64'h1);
    chk("commit_full_head", {8'h0, req_addr_o}, 64'h4000);
    tick();
    sample();
    chk("commit_held_off", {63'h0, commit_ready_o}, 64'h0);
    tick();
    drv(1'b0, 56'h0, 64'h0, 8'h00, 2'd0, 1'b1, 1'b1, 1'b0, 12'h000); sample();
    chk("full_grant_cready", {63'h0, commit_ready_o}, 64'h0);
    tick();
    drv(1'b0, 56'h0, 64'h0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 12'h000); sample();
    chk("after_grant_cready", {63'h0, commit_ready_o}, 64'h1);
    chk("after_grant_head", {8'h0, req_addr_o}, 64'h4008);
    tick();
    idle(); sample();
    chk("refilled_cready", {63'h0, commit_ready_o}, 64'h0);
    tick();
    drv(1'b0, 56'h0, 64'h0, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0, 12'h000); sample();
    chk("drain_head0", {8'h0, req_addr_o}, 64'h4008);
    tick(); sample();
    chk("drain_head1", {8'h0, req_addr_o}, 64'h4010);
    tick();

    // Reset with both queues occupied.
    idle();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    sample();
    chk("midrun_reset_flags", {58'h0, ready_o, commit_ready_o, empty_o, no_st_pending_o, req_o, page_offset_matches_o},
        {58'h0, 6'b111_100});
    chk("midrun_reset_addr", {8'h0, req_addr_o}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
